pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register: owns the PC and the next-PC select.

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_fetch_unit_pc_next_sel.sv | 16 +
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word, default reset PC.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Redirect priority and target alignment: a taken branch (older, from EX) beats a jump (from ID).
module pc_fetch_unit_pc_next_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic        Brch,
  input  logic [31:0] BrchTarget,
  input  logic        Jmp,
  input  logic [31:0] JmpTarget,
  output logic        redirect,
  output logic [31:0] target
);

  assign redirect = Brch | Jmp;
  assign target   = word_align(Brch ? BrchTarget : JmpTarget);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack imem handshake and feeds IF/ID,
// inserting NOP bubbles for stalls, outstanding fetches and killed instructions.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        Brch,
  input  logic [31:0] BrchTarget,
  input  logic        Jmp,
  input  logic [31:0] JmpTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_o,
  output logic [31:0] PC_4_o,
  output logic        fetch_valid
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  hold_instr_reg, hold_instr_next;
  logic [31:0]  pend_tgt_reg, pend_tgt_next;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  pc_fetch_unit_pc_next_sel u_next_sel (
    .Brch       (Brch),
    .BrchTarget (BrchTarget),
    .Jmp        (Jmp),
    .JmpTarget  (JmpTarget),
    .redirect   (redirect),
    .target     (target)
  );

  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= word_align(RESET_PC);
      hold_instr_reg <= NOP;
      pend_tgt_reg   <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      hold_instr_reg <= hold_instr_next;
      pend_tgt_reg   <= pend_tgt_next;
    end
  end

  // A redirect never aborts an outstanding request; DRAIN lets it finish and discards the data.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    hold_instr_next = hold_instr_reg;
    pend_tgt_next   = pend_tgt_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (redirect && imem_ack) begin
          pc_next = target;
        end else if (redirect) begin
          pend_tgt_next = target;
          state_next    = ST_DRAIN;
        end else if (imem_ack && PCWrite) begin
          pc_next = pc_plus4;
        end else if (imem_ack) begin
          hold_instr_next = imem_rdata;
          state_next      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = ST_WAIT;
        end else if (PCWrite) begin
          pc_next    = pc_plus4;
          state_next = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (redirect) pend_tgt_next = target;
        if (imem_ack) begin
          pc_next    = redirect ? target : pend_tgt_reg;
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_reg == ST_WAIT) || (state_reg == ST_DRAIN);
    imem_addr   = pc_reg;
    fetch_valid = (((state_reg == ST_WAIT) && imem_ack) || (state_reg == ST_HOLD)) && !redirect;
    Instr_o     = NOP;
    if (fetch_valid) Instr_o = (state_reg == ST_HOLD) ? hold_instr_reg : imem_rdata;
    PC_4_o      = pc_plus4;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle vector table plus a random-latency fetch run.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b0;
  logic        Brch = 1'b0;
  logic [31:0] BrchTarget = 32'h0;
  logic        Jmp = 1'b0;
  logic [31:0] JmpTarget = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_o;
  logic [31:0] PC_4_o;
  logic        fetch_valid;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCWrite     (PCWrite),
    .Brch        (Brch),
    .BrchTarget  (BrchTarget),
    .Jmp         (Jmp),
    .JmpTarget   (JmpTarget),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instr_o     (Instr_o),
    .PC_4_o      (PC_4_o),
    .fetch_valid (fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: data only meaningful on ack; junk otherwise so stale captures show up.
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    bit          rst;
    bit          pcw;
    bit          brch;
    logic [31:0] btgt;
    bit          jmp;
    logic [31:0] jtgt;
    bit          ack;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic [31:0] addr_q[$];

  function automatic vec_t mk(bit rst, bit pcw, bit brch, logic [31:0] btgt, bit jmp,
                              logic [31:0] jtgt, bit ack, bit e_req, logic [31:0] e_addr,
                              bit e_valid);
    vec_t v;
    v.rst = rst; v.pcw = pcw; v.brch = brch; v.btgt = btgt; v.jmp = jmp; v.jtgt = jtgt;
    v.ack = ack; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    vec_t e;
    logic [31:0] ea;
    int cycles;
    bit ok;

    // rst pcw brch btgt jmp jtgt ack | req addr valid
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h0,0));              // in reset
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h0,0));              // IDLE
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,1));              // ack every cycle
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h4,1));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h8,1));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'hC,1));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h10,0));             // ack 3 cycles late
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h10,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h10,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h10,1));
    vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'h14,1));             // ack with stall -> HOLD
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h14,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h14,1));
    vecs.push_back(mk(0,1,0,0,0,0,0, 0,32'h14,1));             // release stall
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h18,0));
    vecs.push_back(mk(0,1,0,0,1,32'h40,0, 1,32'h18,0));        // jump, no ack -> DRAIN
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h18,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h18,0));             // orphan ack dropped
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h40,1));
    vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'h44,1));             // -> HOLD
    vecs.push_back(mk(0,0,1,32'h80,1,32'h40,0, 0,32'h44,0));   // brch+jmp kill held word
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h80,1));
    vecs.push_back(mk(0,1,1,32'h101,0,0,1, 1,32'h84,0));       // redirect with ack, misaligned
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h100,1));
    vecs.push_back(mk(0,1,0,0,1,32'h200,0, 1,32'h104,0));      // DRAIN, latest target wins
    vecs.push_back(mk(0,1,1,32'h300,0,0,0, 1,32'h104,0));
    vecs.push_back(mk(0,1,0,0,1,32'h400,1, 1,32'h104,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h400,1));
    vecs.push_back(mk(0,1,0,0,1,32'hFFFF_FFFE,1, 1,32'h404,0)); // jump near top of memory
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'hFFFF_FFFC,1));      // pc+4 wraps
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,1));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h4,0));              // WAIT, request open
    vecs.push_back(mk(1,1,0,0,0,0,0, 0,32'h0,0));              // reset mid-fetch
    vecs.push_back(mk(0,1,0,0,0,0,0, 0,32'h0,0));              // IDLE
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,1));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h4,1));

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      rst_n = ~v.rst;
      PCWrite = v.pcw; Brch = v.brch; BrchTarget = v.btgt;
      Jmp = v.jmp; JmpTarget = v.jtgt; imem_ack = v.ack;
      exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("r%0d_req", i), {31'b0, imem_req}, {31'b0, e.e_req});
      chk($sformatf("r%0d_addr", i), imem_addr, e.e_addr);
      chk($sformatf("r%0d_valid", i), {31'b0, fetch_valid}, {31'b0, e.e_valid});
      chk($sformatf("r%0d_instr", i), Instr_o, e.e_valid ? mem_word(e.e_addr) : 32'h0);
      chk($sformatf("r%0d_pc4", i), PC_4_o, e.e_addr + 32'd4);
      $display("[TB] row %0d req=%0b addr=%h valid=%0b instr=%h", i, imem_req, imem_addr,
               fetch_valid, Instr_o);
    end

    // Random ack latency with no stall: the next 8 fetches must be sequential from 0x8.
    Brch = 1'b0; Jmp = 1'b0; PCWrite = 1'b1;
    for (int k = 0; k < 8; k++) addr_q.push_back(32'h8 + 32'(k) * 32'd4);
    cycles = 0;
    while (addr_q.size() != 0 && cycles < 200) begin
      @(negedge clk);
      imem_ack = ($urandom_range(0, 2) == 0);
      #1;
      cycles++;
      if (fetch_valid) begin
        ea = addr_q.pop_front();
        chk("rnd_addr", imem_addr, ea);
        chk("rnd_instr", Instr_o, mem_word(ea));
        $display("[TB] rnd fetch addr=%h instr=%h after %0d cycles", imem_addr, Instr_o, cycles);
      end else begin
        ok = (imem_req == 1'b1) && (Instr_o == 32'h0);
        chk("rnd_bubble", {31'b0, ok}, 32'h1);
      end
    end
    chk("rnd_drained", addr_q.size(), 32'd0);

    imem_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
